// File: rtl/minibyte_bus_arbiter.sv
// Two-master arbiter for the shared 8-bit Minibyte memory/IO bus with programmable wait states.
// Define MINIBYTE_ARB_RR_EN for round-robin tie-breaking; otherwise master 0 has fixed priority.
module minibyte_bus_arbiter #(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_req,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic              m0_we,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic              m1_we,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  output logic              bus_we,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic              busy,
  output logic              owner
);

  // Wait count is a 4-bit counter; WAIT_CYCLES above 15 is not supported.
  localparam logic [3:0] WaitInit = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {StIdle, StAccess, StAck} state_e;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              owner_q, owner_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;
  logic              any_req;
  logic              win;

  assign any_req = m0_req | m1_req;

`ifdef MINIBYTE_ARB_RR_EN
  logic ptr_q, ptr_d;

  // On a tie the master that did not win last time is granted.
  assign win = (m0_req & m1_req) ? ~ptr_q : ~m0_req;

  always_comb begin
    ptr_d = ptr_q;
    if (state_q == StIdle && any_req) ptr_d = win;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= 1'b1;
    else        ptr_q <= ptr_d;
  end
`else
  assign win = ~m0_req;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    owner_d  = owner_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    unique case (state_q)
      StIdle: begin
        if (any_req) begin
          owner_d = win;
          addr_d  = win ? m1_addr  : m0_addr;
          wdata_d = win ? m1_wdata : m0_wdata;
          we_d    = win ? m1_we    : m0_we;
          cnt_d   = WaitInit;
          state_d = StAccess;
        end
      end
      StAccess: begin
        if (cnt_q == 4'd0) begin
          state_d = StAck;
          if (!we_q) begin
            if (owner_q) rdata1_d = bus_rdata;
            else         rdata0_d = bus_rdata;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StAck:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= 4'd0;
      owner_q  <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      owner_q  <= owner_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  // Strobe is decoded from state so reset drops it without waiting for a clock edge.
  assign bus_we    = (state_q == StAccess) & we_q;
  assign busy      = (state_q != StIdle);
  assign m0_ack    = (state_q == StAck) & ~owner_q;
  assign m1_ack    = (state_q == StAck) &  owner_q;
  assign bus_addr  = addr_q;
  assign bus_wdata = wdata_q;
  assign owner     = owner_q;
  assign m0_rdata  = rdata0_q;
  assign m1_rdata  = rdata1_q;

endmodule

// File: tb/tb_minibyte_bus_arbiter.sv
// Randomized scoreboard bench for minibyte_bus_arbiter: one DUT with no wait states, one with 3.
// Honours MINIBYTE_ARB_RR_EN the same way the design does.
module tb_minibyte_bus_arbiter;

  localparam int NI = 2;

  typedef struct {
    bit         m;
    int         cyc;
    logic [7:0] rd;
  } txn_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   cyc   = 0;

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic       req      [NI][2];
  logic       we_in    [NI][2];
  logic [7:0] addr_in  [NI][2];
  logic [7:0] wdata_in [NI][2];
  logic       ack      [NI][2];
  logic [7:0] rdata    [NI][2];
  logic [7:0] bus_addr [NI];
  logic [7:0] bus_wdata[NI];
  logic [7:0] bus_rdata[NI];
  logic       bus_we   [NI];
  logic       busy     [NI];
  logic       owner    [NI];

  // Bus read data depends on address and cycle, so sampling on the wrong cycle shows up.
  function automatic logic [7:0] rd_fn(input logic [7:0] a, input int c);
    int t;
    t = (int'(a) * 3) ^ (c * 29);
    return t[7:0];
  endfunction

  function automatic int wait_of(input int i);
    return (i == 0) ? 0 : 3;
  endfunction

  for (genvar g = 0; g < NI; g++) begin : gen_dut
    localparam int unsigned W = (g == 0) ? 0 : 3;
    assign bus_rdata[g] = rd_fn(bus_addr[g], cyc);
    minibyte_bus_arbiter #(
      .ADDR_W     (8),
      .DATA_W     (8),
      .WAIT_CYCLES(W)
    ) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .m0_req   (req[g][0]),
      .m0_addr  (addr_in[g][0]),
      .m0_wdata (wdata_in[g][0]),
      .m0_we    (we_in[g][0]),
      .m0_ack   (ack[g][0]),
      .m0_rdata (rdata[g][0]),
      .m1_req   (req[g][1]),
      .m1_addr  (addr_in[g][1]),
      .m1_wdata (wdata_in[g][1]),
      .m1_we    (we_in[g][1]),
      .m1_ack   (ack[g][1]),
      .m1_rdata (rdata[g][1]),
      .bus_addr (bus_addr[g]),
      .bus_wdata(bus_wdata[g]),
      .bus_we   (bus_we[g]),
      .bus_rdata(bus_rdata[g]),
      .busy     (busy[g]),
      .owner    (owner[g])
    );
  end

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input int inst, input logic [63:0] act,
                       input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s [dut%0d wait=%0d] cycle %0d: got 0x%0h, expected 0x%0h",
                  name, inst, wait_of(inst), cyc, act, exp);
  endtask

  // Reference model: a timeline of granted transactions per DUT.
  txn_t       sb_q     [NI][$];
  bit         have     [NI];
  int         gc       [NI];
  bit         cur_m    [NI];
  bit         cur_we   [NI];
  logic [7:0] cur_addr [NI];
  logic [7:0] cur_wdata[NI];
  bit         ptr      [NI];
  logic [7:0] last_rd  [NI][2];
  int         ack_at   [NI][2];
  bit         exp_busy [NI];
  bit         exp_we   [NI];
  bit         own_sh   [NI];
  logic [7:0] addr_sh  [NI];
  logic [7:0] wdata_sh [NI];
  bit         outstanding[NI][2];

  initial begin : model
    int   c, w;
    bit   r0, r1, win;
    txn_t t;
    forever begin
      @(negedge clk);
      c = cyc;
      for (int i = 0; i < NI; i++) begin
        if (!rst_n) begin
          have[i] = 1'b0; ptr[i] = 1'b1; own_sh[i] = 1'b0;
          addr_sh[i] = 8'h00; wdata_sh[i] = 8'h00;
          exp_busy[i] = 1'b0; exp_we[i] = 1'b0;
          for (int m = 0; m < 2; m++) begin
            last_rd[i][m] = 8'h00;
            ack_at[i][m]  = -1;
          end
          continue;
        end
        w = wait_of(i);
        if (have[i] && c == gc[i] + 1) begin
          addr_sh[i]  = cur_addr[i];
          wdata_sh[i] = cur_wdata[i];
          own_sh[i]   = cur_m[i];
        end
        exp_busy[i] = have[i] && c >= gc[i] + 1 && c <= gc[i] + 2 + w;
        exp_we[i]   = have[i] && c >= gc[i] + 1 && c <= gc[i] + 1 + w && cur_we[i];
        r0 = req[i][0];
        r1 = req[i][1];
        if (!exp_busy[i] && (r0 || r1)) begin
`ifdef MINIBYTE_ARB_RR_EN
          win = (r0 && r1) ? !ptr[i] : r1;
`else
          win = (r0 && r1) ? 1'b0 : r1;
`endif
          ptr[i]       = win;
          have[i]      = 1'b1;
          gc[i]        = c;
          cur_m[i]     = win;
          cur_we[i]    = we_in[i][win];
          cur_addr[i]  = addr_in[i][win];
          cur_wdata[i] = wdata_in[i][win];
          if (!cur_we[i]) last_rd[i][win] = rd_fn(cur_addr[i], c + 1 + w);
          t.m   = win;
          t.cyc = c + 2 + w;
          t.rd  = last_rd[i][win];
          ack_at[i][win] = t.cyc;
          sb_q[i].push_back(t);
        end
      end
    end
  end

  initial begin : monitor
    int   c;
    txn_t t;
    forever begin
      @(negedge clk);
      #1;
      c = cyc;
      for (int i = 0; i < NI; i++) begin
        if (!rst_n) begin
          check("reset_outputs", i, {bus_addr[i], bus_wdata[i], bus_we[i], busy[i], owner[i],
                ack[i][0], ack[i][1], rdata[i][0], rdata[i][1]}, 64'd0);
          sb_q[i].delete();
          continue;
        end
        check("busy", i, 64'(busy[i]), 64'(exp_busy[i]));
        check("bus_we", i, 64'(bus_we[i]), 64'(exp_we[i]));
        check("owner", i, 64'(owner[i]), 64'(own_sh[i]));
        check("bus_addr", i, 64'(bus_addr[i]), 64'(addr_sh[i]));
        check("bus_wdata", i, 64'(bus_wdata[i]), 64'(wdata_sh[i]));
        check("single_ack", i, 64'(ack[i][0] & ack[i][1]), 64'd0);
        if (ack[i][0] || ack[i][1]) begin
          if (sb_q[i].size() == 0) begin
            check("spurious_ack", i, 64'({ack[i][1], ack[i][0]}), 64'd0);
          end else begin
            t = sb_q[i].pop_front();
            check("ack_master", i, 64'(ack[i][1]), 64'(t.m));
            check("ack_cycle", i, 64'(c), 64'(t.cyc));
            check("ack_rdata", i, 64'(rdata[i][t.m]), 64'(t.rd));
          end
        end else if (sb_q[i].size() > 0 && sb_q[i][0].cyc <= c) begin
          t = sb_q[i].pop_front();
          check("ack_missing", i, 64'({ack[i][1], ack[i][0]}), 64'(2'b01 << t.m));
        end
      end
    end
  end

  // load: 0 = random requests, 1 = requests re-raised at once, 2 = no new requests.
  task automatic step(input int load);
    for (int i = 0; i < NI; i++) begin
      for (int m = 0; m < 2; m++) begin
        if (!rst_n) begin
          req[i][m] = 1'b0;
          outstanding[i][m] = 1'b0;
        end else if (outstanding[i][m]) begin
          if (ack_at[i][m] == cyc - 1) begin
            req[i][m] = 1'b0;
            outstanding[i][m] = 1'b0;
          end else if (ack_at[i][m] >= cyc) begin
            // Already latched by the DUT: disturbing the inputs must have no effect.
            if ($urandom_range(0, 3) == 0) begin
              addr_in[i][m]  = 8'($urandom);
              wdata_in[i][m] = 8'($urandom);
              we_in[i][m]    = 1'($urandom);
            end
            if ($urandom_range(0, 7) == 0) req[i][m] = 1'b0;
          end
        end else if (load != 2 && (load == 1 || $urandom_range(0, 2) == 0)) begin
          req[i][m]      = 1'b1;
          addr_in[i][m]  = 8'($urandom);
          wdata_in[i][m] = 8'($urandom);
          we_in[i][m]    = 1'($urandom);
          outstanding[i][m] = 1'b1;
        end
      end
    end
  endtask

  task automatic drive(input int n, input int load);
    repeat (n) begin
      @(posedge clk);
      #1;
      step(load);
    end
  endtask

  initial begin : stimulus
    for (int i = 0; i < NI; i++) begin
      for (int m = 0; m < 2; m++) begin
        req[i][m] = 1'b0; we_in[i][m] = 1'b0;
        addr_in[i][m] = 8'h00; wdata_in[i][m] = 8'h00;
        outstanding[i][m] = 1'b0;
      end
    end
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    drive(400, 0);
    drive(200, 1);
    // Asynchronous reset in the middle of traffic, away from any clock edge.
    #2 rst_n = 1'b0;
    drive(3, 0);
    #2 rst_n = 1'b1;
    drive(20, 2);
    drive(400, 0);
    drive(150, 1);
    drive(30, 2);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
